// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle Small-MIPS datapath: sequences
// fetch/decode/execute/memory/writeback, stalls on memory ready, counts retirements.
module mips_multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [5:0]       i_op,
    input  logic             i_memReady,
    output logic             o_pcWrite,
    output logic             o_pcWriteCond,
    output logic             o_iorD,
    output logic             o_memRead,
    output logic             o_memWrite,
    output logic             o_irWrite,
    output logic             o_memToReg,
    output logic             o_regDst,
    output logic             o_regWrite,
    output logic             o_aluSrcA,
    output logic [1:0]       o_aluSrcB,
    output logic [1:0]       o_aluOp,
    output logic [1:0]       o_pcSource,
    output logic             o_illegal,
    output logic [3:0]       o_state,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    state_t           state_reg;
    state_t           state_next;
    logic [5:0]       op_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             retire_next;
    logic             op_supported;

    always_comb begin
        op_supported = 1'b0;
        case (i_op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_supported = 1'b1;
            default:                                   op_supported = 1'b0;
        endcase
    end

    // Next state and retirement: retiring states always return to FETCH.
    always_comb begin
        state_next  = S_FETCH;
        retire_next = 1'b0;
        case (state_reg)
            S_FETCH:  state_next = i_memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_op)
                    OP_R:         state_next = S_EXEC;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDIEX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op_reg == OP_SW)
                    state_next = S_MEMWR;
                else if (op_reg == OP_LW)
                    state_next = S_MEMRD;
                else
                    state_next = S_FETCH;
            end
            S_MEMRD:  state_next = i_memReady ? S_MEMWB : S_MEMRD;
            S_MEMWB: begin
                state_next  = S_FETCH;
                retire_next = 1'b1;
            end
            S_MEMWR: begin
                state_next  = i_memReady ? S_FETCH : S_MEMWR;
                retire_next = i_memReady;
            end
            S_EXEC:   state_next = S_ALUWB;
            S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
                state_next  = S_FETCH;
                retire_next = 1'b1;
            end
            S_ADDIEX: state_next = S_ADDIWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg   <= S_FETCH;
            op_reg      <= '0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE)
                op_reg <= i_op;
            if (retire_next)
                retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    // Datapath controls decode from the current state; write strobes are masked during reset.
    always_comb begin
        o_pcWrite     = 1'b0;
        o_pcWriteCond = 1'b0;
        o_iorD        = 1'b0;
        o_memRead     = 1'b0;
        o_memWrite    = 1'b0;
        o_irWrite     = 1'b0;
        o_memToReg    = 1'b0;
        o_regDst      = 1'b0;
        o_regWrite    = 1'b0;
        o_aluSrcA     = 1'b0;
        o_aluSrcB     = 2'b00;
        o_aluOp       = 2'b00;
        o_pcSource    = 2'b00;
        o_illegal     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                o_memRead = 1'b1;
                o_aluSrcB = 2'b01;
                o_irWrite = i_memReady;
                o_pcWrite = i_memReady;
            end
            S_DECODE: begin
                o_aluSrcB = 2'b11;
                o_illegal = ~op_supported;
            end
            S_MEMADR: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                o_memRead = 1'b1;
                o_iorD    = 1'b1;
            end
            S_MEMWB: begin
                o_regWrite = 1'b1;
                o_memToReg = 1'b1;
            end
            S_MEMWR: begin
                o_memWrite = 1'b1;
                o_iorD     = 1'b1;
            end
            S_EXEC: begin
                o_aluSrcA = 1'b1;
                o_aluOp   = 2'b10;
            end
            S_ALUWB: begin
                o_regWrite = 1'b1;
                o_regDst   = 1'b1;
            end
            S_BRANCH: begin
                o_aluSrcA     = 1'b1;
                o_aluOp       = 2'b01;
                o_pcWriteCond = 1'b1;
                o_pcSource    = 2'b01;
            end
            S_JUMP: begin
                o_pcWrite  = 1'b1;
                o_pcSource = 2'b10;
            end
            S_ADDIEX: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = 2'b10;
            end
            S_ADDIWB: o_regWrite = 1'b1;
            default: ;
        endcase
        if (i_reset) begin
            o_irWrite     = 1'b0;
            o_pcWrite     = 1'b0;
            o_pcWriteCond = 1'b0;
            o_memWrite    = 1'b0;
            o_regWrite    = 1'b0;
            o_illegal     = 1'b0;
        end
    end

    assign o_state   = state_reg;
    assign o_retired = retired_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-cycle vectors pushed to a
// scoreboard when driven and compared at the following falling edge.
module tb_mips_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic        rdy;

    logic        pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [15:0] retired;

    logic        s_pc_write, s_pc_write_cond, s_ior_d, s_mem_read, s_mem_write, s_ir_write;
    logic        s_mem_to_reg, s_reg_dst, s_reg_write, s_alu_src_a, s_illegal;
    logic [1:0]  s_alu_src_b, s_alu_op, s_pc_source;
    logic [3:0]  s_state;
    logic [3:0]  s_retired;

    always #5 clk = ~clk;

    mips_multicycle_control #(.CNT_W(16)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_op(op), .i_memReady(rdy),
        .o_pcWrite(pc_write), .o_pcWriteCond(pc_write_cond), .o_iorD(ior_d),
        .o_memRead(mem_read), .o_memWrite(mem_write), .o_irWrite(ir_write),
        .o_memToReg(mem_to_reg), .o_regDst(reg_dst), .o_regWrite(reg_write),
        .o_aluSrcA(alu_src_a), .o_aluSrcB(alu_src_b), .o_aluOp(alu_op),
        .o_pcSource(pc_source), .o_illegal(illegal), .o_state(state),
        .o_retired(retired)
    );

    // Narrow-counter copy makes the wrap boundary reachable in a short run.
    mips_multicycle_control #(.CNT_W(4)) u_small (
        .i_clk(clk), .i_reset(rst), .i_op(op), .i_memReady(rdy),
        .o_pcWrite(s_pc_write), .o_pcWriteCond(s_pc_write_cond), .o_iorD(s_ior_d),
        .o_memRead(s_mem_read), .o_memWrite(s_mem_write), .o_irWrite(s_ir_write),
        .o_memToReg(s_mem_to_reg), .o_regDst(s_reg_dst), .o_regWrite(s_reg_write),
        .o_aluSrcA(s_alu_src_a), .o_aluSrcB(s_alu_src_b), .o_aluOp(s_alu_op),
        .o_pcSource(s_pc_source), .o_illegal(s_illegal), .o_state(s_state),
        .o_retired(s_retired)
    );

    logic [16:0] act_ctl;
    assign act_ctl = {pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, illegal};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [15:0] ret;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [16:0] c_fetch, c_fetch_rdy, c_fetch_rst, c_decode, c_decode_ill, c_memadr;
    logic [16:0] c_memrd, c_memwb, c_memwr, c_exec, c_aluwb, c_branch, c_jump;
    logic [16:0] c_addiex, c_addiwb;

    function automatic logic [16:0] ctl(
        input logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa,
        input logic [1:0] asb, aop, ps, input logic ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, ill};
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic y,
                       input logic [3:0] st, input logic [16:0] c, input logic [15:0] rt);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = y; v.st = st; v.ctl = c; v.ret = rt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h want %0h", name, idx, got, want);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        rst = v.rst; op = v.op; rdy = v.rdy;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        $display("[TB] row %0d rst=%0b op=%02h rdy=%0b state=%0d ctl=%05h retired=%0d",
                 idx, e.rst, e.op, e.rdy, state, act_ctl, retired);
        check("state",   idx, 32'(state),     32'(e.st));
        check("ctl",     idx, 32'(act_ctl),   32'(e.ctl));
        check("retired", idx, 32'(retired),   32'(e.ret));
        check("retired4", idx, 32'(s_retired), 32'(e.ret[3:0]));
    endtask

    initial begin
        rst = 1'b1; op = 6'h00; rdy = 1'b1;

        c_fetch      = ctl(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        c_fetch_rdy  = ctl(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
        c_fetch_rst  = ctl(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        c_decode     = ctl(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
        c_decode_ill = ctl(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
        c_memadr     = ctl(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        c_memrd      = ctl(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        c_memwb      = ctl(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
        c_memwr      = ctl(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        c_exec       = ctl(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
        c_aluwb      = ctl(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
        c_branch     = ctl(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        c_jump       = ctl(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
        c_addiex     = ctl(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        c_addiwb     = ctl(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);

        // Reset held, then LW with ready every cycle: 0,1,2,3,4 -> retire.
        add(1, 6'h23, 1, 0, c_fetch_rst, 0);
        add(0, 6'h23, 1, 0, c_fetch_rdy, 0);
        add(0, 6'h23, 1, 1, c_decode,    0);
        add(0, 6'h23, 1, 2, c_memadr,    0);
        add(0, 6'h23, 1, 3, c_memrd,     0);
        add(0, 6'h23, 1, 4, c_memwb,     0);
        // R-type.
        add(0, 6'h00, 1, 0, c_fetch_rdy, 1);
        add(0, 6'h00, 1, 1, c_decode,    1);
        add(0, 6'h00, 1, 6, c_exec,      1);
        add(0, 6'h00, 1, 7, c_aluwb,     1);
        // SW; opcode input changes after decode, MEMWR waits 3 cycles for ready.
        add(0, 6'h2B, 1, 0, c_fetch_rdy, 2);
        add(0, 6'h2B, 1, 1, c_decode,    2);
        add(0, 6'h00, 1, 2, c_memadr,    2);
        add(0, 6'h00, 0, 5, c_memwr,     2);
        add(0, 6'h00, 0, 5, c_memwr,     2);
        add(0, 6'h00, 0, 5, c_memwr,     2);
        add(0, 6'h00, 1, 5, c_memwr,     2);
        // BEQ, with one fetch stall first.
        add(0, 6'h04, 0, 0, c_fetch,     3);
        add(0, 6'h04, 1, 0, c_fetch_rdy, 3);
        add(0, 6'h04, 1, 1, c_decode,    3);
        add(0, 6'h04, 1, 8, c_branch,    3);
        // J.
        add(0, 6'h02, 1, 0, c_fetch_rdy, 4);
        add(0, 6'h02, 1, 1, c_decode,    4);
        add(0, 6'h02, 1, 9, c_jump,      4);
        // ADDI.
        add(0, 6'h08, 1, 0,  c_fetch_rdy, 5);
        add(0, 6'h08, 1, 1,  c_decode,    5);
        add(0, 6'h08, 1, 10, c_addiex,    5);
        add(0, 6'h08, 1, 11, c_addiwb,    5);
        // Illegal opcode: one-cycle pulse, back to FETCH, no retirement.
        add(0, 6'h3F, 1, 0, c_fetch_rdy,  6);
        add(0, 6'h3F, 1, 1, c_decode_ill, 6);
        // LW stalled in MEMRD, then reset with ready high: reset must win.
        add(0, 6'h23, 1, 0, c_fetch_rdy, 6);
        add(0, 6'h23, 1, 1, c_decode,    6);
        add(0, 6'h23, 1, 2, c_memadr,    6);
        add(0, 6'h23, 0, 3, c_memrd,     6);
        add(0, 6'h23, 0, 3, c_memrd,     6);
        add(1, 6'h23, 1, 3, c_memrd,     6);
        add(0, 6'h00, 0, 0, c_fetch,     0);
        // Sixteen jumps: 4-bit counter wraps to 0 while the 16-bit one reaches 16.
        for (int i = 0; i < 16; i++) begin
            add(0, 6'h02, 1, 0, c_fetch_rdy, 16'(i));
            add(0, 6'h02, 1, 1, c_decode,    16'(i));
            add(0, 6'h02, 1, 9, c_jump,      16'(i));
        end
        add(0, 6'h00, 0, 0, c_fetch, 16);

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++)
            run_vec(i, vecs[i]);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle Small-MIPS datapath; sits directly upstream of the ALU control decoder.
- Decodes the IR opcode and sequences Fetch/Decode/Execute/Memory/Writeback.
- Drives all datapath enables, including the 2-bit ALU-op code consumed by the ALU control decoder.
- Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_op  in  6  opcode field IR[31:26]; valid from DECODE onward.
- i_memReady  in  1  memory access completes this cycle.
- o_pcWrite  out  1  unconditional PC write.
- o_pcWriteCond  out  1  PC write if ALU zero.
- o_iorD  out  1  memory address: 0=PC, 1=ALUOut.
- o_memRead  out  1  memory read request.
- o_memWrite  out  1  memory write request.
- o_irWrite  out  1  load IR.
- o_memToReg  out  1  register write data: 0=ALUOut, 1=MDR.
- o_regDst  out  1  destination register: 0=rt, 1=rd.
- o_regWrite  out  1  register file write.
- o_aluSrcA  out  1  ALU A: 0=PC, 1=rs.
- o_aluSrcB  out  2  ALU B: 00=rt, 01=4, 10=signext imm, 11=signext imm<<2.
- o_aluOp  out  2  ALU-op code: 00=add, 01=sub, 10=funct-decode.
- o_pcSource  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- o_illegal  out  1  one-cycle pulse on unsupported opcode.
- o_state  out  4  current state, for debug.
- o_retired  out  CNT_W  retired-instruction count.

Behaviour:
- Supported opcodes: R=0x00, LW=0x23, SW=0x2B, BEQ=0x04, J=0x02, ADDI=0x08.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12-15 go to FETCH next cycle with all outputs 0.
- Outputs decode from state (plus i_memReady where noted); every output not listed for a state is 0.
  - FETCH: memRead=1, aluSrcB=01. irWrite=pcWrite=i_memReady. Stay in FETCH until i_memReady, then go to DECODE.
  - DECODE: aluSrcB=11. Latch i_op into an internal op register. Next state: R->EXEC, LW/SW->MEMADR, BEQ->BRANCH, J->JUMP, ADDI->ADDIEX. Any other opcode: o_illegal=1 this cycle, next state FETCH.
  - MEMADR: aluSrcA=1, aluSrcB=10. Uses the latched op: LW->MEMRD, SW->MEMWR.
  - MEMRD: memRead=1, iorD=1. Go to MEMWB when i_memReady, else hold.
  - MEMWB: regWrite=1, memToReg=1, regDst=0. Next FETCH.
  - MEMWR: memWrite=1, iorD=1. Go to FETCH when i_memReady, else hold.
  - EXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Next ALUWB.
  - ALUWB: regWrite=1, regDst=1. Next FETCH.
  - BRANCH: aluSrcA=1, aluOp=01, pcWriteCond=1, pcSource=01. Next FETCH.
  - JUMP: pcWrite=1, pcSource=10. Next FETCH.
  - ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00. Next ADDIWB.
  - ADDIWB: regWrite=1, regDst=0. Next FETCH.
- Request hold: memRead and memWrite stay asserted, with iorD stable, every cycle until i_memReady. There is no timeout.
- Retire counter: o_retired increments by 1 on each transition to FETCH from MEMWB, MEMWR (with ready), ALUWB, BRANCH, JUMP or ADDIWB.
  - Illegal opcodes do not retire.
  - The counter wraps modulo 2^CNT_W.
- Latency in cycles, memReady=1 always: LW=5, SW=4, R=4, ADDI=4, BEQ=3, J=3.
- Reset:
  - At any rising edge with i_reset=1: state<=FETCH, o_retired<=0, latched op<=0. Reset wins over every pending transition, including mid-memory-wait.
  - While i_reset=1, o_irWrite, o_pcWrite, o_pcWriteCond, o_memWrite, o_regWrite and o_illegal are forced to 0, whatever i_memReady is.
  - After reset: o_state=0, o_memRead=1, o_aluSrcB=01, all other outputs 0.

Test Plan:
- Reset, then LW (0x23) with memReady=1 every cycle -> states 0,1,2,3,4,0. regWrite and memToReg high in state 4 only. o_retired=1 after 5 cycles.
- R-type (0x00) -> o_aluOp=10 exactly in EXEC. regDst=1 and regWrite=1 in ALUWB. o_retired increments on the return to FETCH.
- SW with memReady low for 3 cycles in MEMWR -> memWrite=1 and iorD=1 held 4 cycles; state 5 until ready, then 0. regWrite never asserted.
- BEQ (0x04) -> aluOp=01, pcWriteCond=1, pcSource=01 for one cycle. J (0x02) -> pcWrite=1, pcSource=10 for one cycle. Each takes 3 cycles.
- Opcode 0x3F in DECODE -> o_illegal=1 for exactly one cycle, next state FETCH, o_retired unchanged.
- i_reset asserted mid-MEMRD with memReady low -> next state 0, o_retired=0, regWrite never pulses. Separately, preload the counter to 0xFFFF and retire one instruction -> o_retired=0x0000.
